iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu_pkg.sv | 25 ++
 rtl/iter_alu_if.sv | 35 +++
 rtl/iter_alu_muldiv_core.sv | 90 +++++++++
 rtl/iter_alu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: shared definitions for the iterative ALU.
//   - op_e    : operation encodings carried on the operation bus
//   - FLAG_*  : bit positions of the status flags in the flag word
//   - state_e : control FSM state encoding (also exported for debug)
package iter_alu_pkg;

    typedef enum logic [1:0] {
        OP_DIV = 2'd0,
        OP_MUL = 2'd1,
        OP_ADD = 2'd2,
        OP_NEG = 2'd3
    } op_e;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_V  = 2;
    localparam int FLAG_DZ = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/iter_alu_if.sv
// iter_alu_if: request/response bundle of the iterative ALU.
//
// Handshake: the master raises start together with operation/a/b/flags_in;
// the request is taken on the rising edge where ready=1 and start=1, and
// start is ignored whenever ready=0. The slave answers with a one-cycle done
// pulse; r/rem/flags_out change only in that cycle and hold until the next
// done or reset.
//
//   master drives : start, operation, a, b, flags_in
//   slave drives  : ready, done, r, rem, flags_out
interface iter_alu_if #(
    parameter int WIDTH   = 16,
    parameter int OP_BITS = 2
);
    logic               start;
    logic [OP_BITS-1:0] operation;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   flags_in;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   flags_out;

    modport master (
        output start, operation, a, b, flags_in,
        input  ready, done, r, rem, flags_out
    );

    modport slave (
        input  start, operation, a, b, flags_in,
        output ready, done, r, rem, flags_out
    );
endinterface

// File: rtl/iter_alu_muldiv_core.sv
// muldiv_core: datapath for unsigned shift-add multiply and restoring divide.
// Operates on magnitudes only; the caller applies signs.
//
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : load magnitudes and mode (is_div_i) for a new operation
//   step_i       : perform one iteration
//   mag_a_i/b_i  : operand magnitudes (A, B)
//   acc_nxt_o    : value acc takes at this edge (MUL: product high half,
//                  DIV: remainder)
//   shr_nxt_o    : value shr takes at this edge (MUL: product low half,
//                  DIV: quotient)
// The *_nxt_o outputs let the owner capture the final result on the same
// edge that performs the last step.
module muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] mag_a_i,
    input  logic [WIDTH-1:0] mag_b_i,
    output logic [WIDTH-1:0] acc_nxt_o,
    output logic [WIDTH-1:0] shr_nxt_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        acc_d     = acc_q;
        shr_d     = shr_q;
        den_d     = den_q;
        div_d     = div_q;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        if (load_i) begin
            // DIV: shr holds the dividend, den the divisor.
            // MUL: shr holds the multiplier, den the multiplicand.
            acc_d = '0;
            div_d = is_div_i;
            shr_d = is_div_i ? mag_a_i : mag_b_i;
            den_d = is_div_i ? mag_b_i : mag_a_i;
        end else if (step_i) begin
            if (div_q) begin
                // Bring in the next dividend bit; subtract if it fits.
                div_shift = {acc_q, shr_q[WIDTH-1]};
                div_diff  = div_shift - {1'b0, den_q};
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                // Add multiplicand on multiplier LSB, then shift the
                // {carry, acc, shr} chain right by one.
                mul_sum = {1'b0, acc_q} + (shr_q[0] ? {1'b0, den_q} : '0);
                acc_d   = mul_sum[WIDTH:1];
                shr_d   = {mul_sum[0], shr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            shr_q <= '0;
            den_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            den_q <= den_d;
            div_q <= div_d;
        end
    end

    assign acc_nxt_o = acc_d;
    assign shr_nxt_o = shr_d;

endmodule

// File: rtl/iter_alu.sv
// iter_alu: iterative signed ALU (DIV, MUL, ADD, NEG) with flag word.
//
//   clk, rst : clock, asynchronous active-high reset
//   bus      : iter_alu_if.slave request/response bundle
//   state_o  : current FSM state (debug)
//
// ADD, NEG and divide-by-zero finish one cycle after accept. MUL and DIV
// iterate WIDTH cycles in muldiv_core and finish WIDTH+1 cycles after accept.
// All results and flags are registered.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    iter_alu_if.slave   bus,
    output state_e      state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    // Upper bits come from the captured flag word; bits 3..0 are status.
    function automatic logic [WIDTH-1:0] mk_flags(
        input logic [WIDTH-1:0] res,
        input logic             v,
        input logic             dz,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH-1:0] f;
        f          = hi & ~WIDTH'(4'hF);
        f[FLAG_Z]  = (res == '0);
        f[FLAG_N]  = res[WIDTH-1];
        f[FLAG_V]  = v;
        f[FLAG_DZ] = dz;
        return f;
    endfunction

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [WIDTH-1:0] fhi_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] flags_q;

    logic op_div, op_mul, op_neg, b_zero, fast, core_load, core_step;

    assign op_div    = (bus.operation == OP_BITS'(OP_DIV));
    assign op_mul    = (bus.operation == OP_BITS'(OP_MUL));
    assign op_neg    = (bus.operation == OP_BITS'(OP_NEG));
    assign b_zero    = (bus.b == '0);
    assign fast      = !(op_mul || (op_div && !b_zero));
    assign core_load = (state_q == S_IDLE) && bus.start && !fast;
    assign core_step = (state_q == S_CALC);

    // Single-cycle results, computed from the request at the accept edge.
    // Encodings beyond NEG (OP_BITS > 2) fall through to ADD.
    logic [WIDTH-1:0] add_sum, fast_r, fast_rem;
    logic             fast_v, fast_dz;

    always_comb begin
        add_sum  = bus.a + bus.b;
        fast_r   = add_sum;
        fast_rem = '0;
        fast_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
        fast_dz  = 1'b0;
        if (op_div) begin
            fast_r   = '0;
            fast_rem = bus.a;
            fast_v   = 1'b0;
            fast_dz  = 1'b1;
        end else if (op_neg) begin
            fast_r = ~bus.a + WIDTH'(1);
            fast_v = (bus.a == MIN_VAL);
        end
    end

    // Sign fix-up of the iterative result, valid on the last CALC edge.
    logic [WIDTH-1:0] acc_nxt, shr_nxt;
    logic [PW-1:0]    prod_mag, prod_s;
    logic [WIDTH-1:0] quot_s, rem_s, slow_r, slow_rem;
    logic             res_neg, mul_v, div_v, slow_v;

    always_comb begin
        res_neg  = a_neg_q ^ b_neg_q;
        prod_mag = {acc_nxt, shr_nxt};
        prod_s   = res_neg ? (~prod_mag + PW'(1)) : prod_mag;
        // Representable iff the top WIDTH+1 bits are a pure sign extension.
        mul_v    = !((&prod_s[PW-1:WIDTH-1]) || !(|prod_s[PW-1:WIDTH-1]));
        quot_s   = res_neg ? (~shr_nxt + WIDTH'(1)) : shr_nxt;
        rem_s    = a_neg_q ? (~acc_nxt + WIDTH'(1)) : acc_nxt;
        // Only MIN / -1 yields a positive quotient with the top bit set.
        div_v    = !res_neg && shr_nxt[WIDTH-1];
        slow_r   = is_div_q ? quot_s : prod_s[WIDTH-1:0];
        slow_rem = is_div_q ? rem_s : '0;
        slow_v   = is_div_q ? div_v : mul_v;
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (core_load),
        .step_i    (core_step),
        .is_div_i  (op_div),
        .mag_a_i   (mag(bus.a)),
        .mag_b_i   (mag(bus.b)),
        .acc_nxt_o (acc_nxt),
        .shr_nxt_o (shr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            fhi_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            r_q      <= '0;
            rem_q    <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        ready_q  <= 1'b0;
                        cnt_q    <= '0;
                        is_div_q <= op_div;
                        a_neg_q  <= bus.a[WIDTH-1];
                        b_neg_q  <= bus.b[WIDTH-1];
                        fhi_q    <= bus.flags_in & ~WIDTH'(4'hF);
                        if (fast) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                            r_q     <= fast_r;
                            rem_q   <= fast_rem;
                            flags_q <= mk_flags(fast_r, fast_v, fast_dz, bus.flags_in);
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        r_q     <= slow_r;
                        rem_q   <= slow_rem;
                        flags_q <= mk_flags(slow_r, slow_v, 1'b0, fhi_q);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.r         = r_q;
    assign bus.rem       = rem_q;
    assign bus.flags_out = flags_q;
    assign state_o       = state_q;

endmodule
